// File: rtl/tilt_servo_ctrl_if.sv
// Tilt input / servo output bundle between the accelerometer front-end and the servo controller.
// Controller side uses the slave modport; the stimulus / upstream side uses master.
interface tilt_servo_ctrl_if;
  logic signed [9:0]  x_in;
  logic signed [9:0]  y_in;
  logic               pwm_x;
  logic               pwm_y;
  logic        [11:0] pulse_x_us;
  logic        [11:0] pulse_y_us;
  logic               ready;

  modport master (
    output x_in, y_in,
    input  pwm_x, pwm_y, pulse_x_us, pulse_y_us, ready
  );

  modport slave (
    input  x_in, y_in,
    output pwm_x, pwm_y, pulse_x_us, pulse_y_us, ready
  );
endinterface

// File: rtl/tilt_servo_ctrl.sv
// Tilt -> dual RC-servo PWM: moving average, deadband/clamp, linear map, per-frame slew (TILT_SERVO_SLEW_EN).
// Latency: target registered 1 cycle after a sample tick; pulse width changes only at frame boundaries.
// Backpressure: none; inputs are sampled free-running on the sample tick, outputs are level signals.
module tilt_servo_ctrl #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int SAMPLE_FREQ  = 100,
  parameter int AVG_LOG2     = 2,
  parameter int FRAME_US     = 20000,
  parameter int PULSE_MIN_US = 1000,
  parameter int PULSE_MAX_US = 2000,
  parameter int DEADBAND     = 8,
  parameter int SLEW_US      = 10
) (
  input  logic               clk,
  input  logic               rst,
  tilt_servo_ctrl_if.slave   bus
);

  localparam int US_DIV   = CLK_FREQ / 1_000_000;
  localparam int SAMP_DIV = CLK_FREQ / SAMPLE_FREQ;
  localparam int USW      = $clog2(US_DIV + 1);
  localparam int SDW      = $clog2(SAMP_DIV + 1);
  localparam int FW       = $clog2(FRAME_US + 1);
  localparam int AVG_N    = 2 ** AVG_LOG2;
  localparam int SUMW     = 10 + AVG_LOG2;
  localparam int FCW      = AVG_LOG2 + 1;
  localparam int HALF     = (PULSE_MAX_US - PULSE_MIN_US) / 2;
  localparam logic [11:0]        CENTER   = 12'((PULSE_MIN_US + PULSE_MAX_US) / 2);
  localparam logic signed [9:0]  TILT_LIM = 10'sd256;
  localparam logic signed [9:0]  DB       = 10'(DEADBAND);

`ifdef TILT_SERVO_SLEW_EN
  localparam bit SLEW_EN = 1'b1;
`else
  localparam bit SLEW_EN = 1'b0;
`endif
  // Without slew limiting the step bound is the full range, so the pulse lands on target in one frame.
  localparam logic [11:0]        SLEW_STEP = 12'(SLEW_EN ? SLEW_US : PULSE_MAX_US);
  localparam logic signed [12:0] SLEW_LIM  = {1'b0, SLEW_STEP};

  typedef enum logic {S_FILL, S_RUN} state_t;

  state_t                  state;
  logic [FCW-1:0]          fill_cnt;
  logic                    ready_q;
  logic [USW-1:0]          us_cnt;
  logic [SDW-1:0]          samp_cnt;
  logic [FW-1:0]           frame_cnt;
  logic [FW-1:0]           frame_nxt;
  logic                    us_tick;
  logic                    samp_tick;
  logic                    samp_d;
  logic                    frame_wrap;
  logic signed [9:0]       din      [2];
  logic signed [9:0]       tap      [2][AVG_N];
  logic signed [SUMW-1:0]  sum      [2];
  logic signed [9:0]       avg      [2];
  logic [11:0]             target   [2];
  logic [11:0]             pulse    [2];
  logic [11:0]             pulse_nxt[2];
  logic [11:0]             pulse_sel[2];
  logic signed [12:0]      diff     [2];
  logic [1:0]              pwm;

  function automatic logic [11:0] map_tilt(input logic signed [9:0] a);
    logic signed [9:0]  c;
    logic signed [19:0] prod;
    if (a > TILT_LIM)       c = TILT_LIM;
    else if (a < -TILT_LIM) c = -TILT_LIM;
    else                    c = a;
    if (c > -DB && c < DB)  c = '0;
    prod = 20'(c) * 20'(HALF);
    return CENTER + 12'(prod >>> 8);
  endfunction

  assign din[0]     = bus.x_in;
  assign din[1]     = bus.y_in;
  assign us_tick    = (us_cnt == USW'(US_DIV - 1));
  assign samp_tick  = (samp_cnt == SDW'(SAMP_DIV - 1));
  assign frame_wrap = us_tick && (frame_cnt == FW'(FRAME_US - 1));
  assign frame_nxt  = frame_wrap ? '0 : (us_tick ? frame_cnt + 1'b1 : frame_cnt);

  always_comb begin
    for (int a = 0; a < 2; a++) begin
      avg[a]  = 10'(sum[a] >>> AVG_LOG2);
      diff[a] = $signed({1'b0, target[a]}) - $signed({1'b0, pulse[a]});
      if (diff[a] > SLEW_LIM)       pulse_nxt[a] = pulse[a] + SLEW_STEP;
      else if (diff[a] < -SLEW_LIM) pulse_nxt[a] = pulse[a] - SLEW_STEP;
      else                          pulse_nxt[a] = target[a];
      pulse_sel[a] = frame_wrap ? pulse_nxt[a] : pulse[a];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      us_cnt   <= '0;
      samp_cnt <= '0;
      samp_d   <= 1'b0;
    end else begin
      us_cnt   <= us_tick ? '0 : us_cnt + 1'b1;
      samp_cnt <= samp_tick ? '0 : samp_cnt + 1'b1;
      samp_d   <= samp_tick;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int a = 0; a < 2; a++) begin
        sum[a] <= '0;
        for (int i = 0; i < AVG_N; i++) tap[a][i] <= '0;
      end
    end else if (samp_tick) begin
      for (int a = 0; a < 2; a++) begin
        sum[a]    <= sum[a] + {{AVG_LOG2{din[a][9]}}, din[a]}
                            - {{AVG_LOG2{tap[a][AVG_N-1][9]}}, tap[a][AVG_N-1]};
        tap[a][0] <= din[a];
        for (int i = 1; i < AVG_N; i++) tap[a][i] <= tap[a][i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_FILL;
      fill_cnt <= '0;
      ready_q  <= 1'b0;
    end else begin
      case (state)
        S_FILL: if (samp_tick) begin
          if (fill_cnt == FCW'(AVG_N - 1)) begin
            state   <= S_RUN;
            ready_q <= 1'b1;
          end else begin
            fill_cnt <= fill_cnt + 1'b1;
          end
        end
        S_RUN:   ready_q <= 1'b1;
        default: state   <= S_FILL;
      endcase
    end
  end

  // pwm is registered from next-state values so it lines up with frame_cnt and drops to 0 in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt <= '0;
      pwm       <= '0;
      for (int a = 0; a < 2; a++) begin
        target[a] <= CENTER;
        pulse[a]  <= CENTER;
      end
    end else begin
      frame_cnt <= frame_nxt;
      for (int a = 0; a < 2; a++) begin
        if (samp_d && state == S_RUN) target[a] <= map_tilt(avg[a]);
        if (frame_wrap)               pulse[a]  <= pulse_nxt[a];
        pwm[a] <= (32'(frame_nxt) < 32'(pulse_sel[a]));
      end
    end
  end

  assign bus.pwm_x      = pwm[0];
  assign bus.pwm_y      = pwm[1];
  assign bus.pulse_x_us = pulse[0];
  assign bus.pulse_y_us = pulse[1];
  assign bus.ready      = ready_q;

endmodule
